// File: rtl/mc_sequencer.sv
// Multicycle instruction sequencer for the Minisys-1A CPU: IF/ID/EXE/MEM/WB
// stepping with memory wait states, bus timeout, mul/div stall and exception entry.
module mc_sequencer #(
  parameter int ADDR_HI_W = 22,
  parameter int MEM_WAIT  = 0,
  parameter int TIMEOUT   = 15   // must exceed MEM_WAIT
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 is_jump,
  input  logic                 is_link,
  input  logic                 is_branch,
  input  logic                 branch_taken,
  input  logic                 is_load,
  input  logic                 is_store,
  input  logic                 is_muldiv,
  input  logic                 muldiv_done,
  input  logic                 except_req,
  input  logic                 is_eret,
  input  logic                 int_req,
  input  logic [ADDR_HI_W-1:0] addr_high,
  input  logic                 mem_ready,
  output logic [2:0]           pc_sel,
  output logic                 wir,
  output logic                 waluresult,
  output logic                 reg_write,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 io_read,
  output logic                 io_write,
  output logic                 exc_entry,
  output logic                 bus_error,
  output logic [2:0]           state
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_INIT = 3'd0,
    S_IF   = 3'd1,
    S_ID   = 3'd2,
    S_EXE  = 3'd3,
    S_MEM  = 3'd4,
    S_WB   = 3'd5,
    S_EXC  = 3'd6
  } state_t;

  localparam logic [2:0] PC_HOLD = 3'b000;
  localparam logic [2:0] PC_INC  = 3'b001;
  localparam logic [2:0] PC_JMP  = 3'b010;
  localparam logic [2:0] PC_BR   = 3'b011;
  localparam logic [2:0] PC_VEC  = 3'b100;
  localparam logic [2:0] PC_EPC  = 3'b101;

  state_t        state_q, state_d;
  logic [CW-1:0] wcnt_q, wcnt_d;
  logic          io;
  logic          mem_exit;

  assign io       = &addr_high;
  // IO space has no ready handshake; only the minimum wait applies.
  assign mem_exit = (wcnt_q >= CW'(MEM_WAIT)) && (io || mem_ready);

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    state_d    = state_q;
    pc_sel     = PC_HOLD;
    wir        = 1'b0;
    waluresult = 1'b0;
    reg_write  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    io_read    = 1'b0;
    io_write   = 1'b0;
    exc_entry  = 1'b0;
    bus_error  = 1'b0;
    case (state_q)
      S_INIT: state_d = S_IF;
      S_IF: begin
        if (int_req) begin
          state_d = S_EXC;
        end else begin
          wir     = 1'b1;
          pc_sel  = PC_INC;
          state_d = S_ID;
        end
      end
      S_ID: begin
        if (except_req) begin
          state_d = S_EXC;
        end else if (is_eret) begin
          pc_sel  = PC_EPC;
          state_d = S_IF;
        end else if (is_jump) begin
          pc_sel    = PC_JMP;
          reg_write = is_link;
          state_d   = S_IF;
        end else begin
          state_d = S_EXE;
        end
      end
      S_EXE: begin
        waluresult = 1'b1;
        if (is_muldiv && !muldiv_done) begin
          state_d = S_EXE;
        end else if (is_load || is_store) begin
          state_d = S_MEM;
        end else if (is_branch) begin
          pc_sel  = branch_taken ? PC_BR : PC_HOLD;
          state_d = is_link ? S_WB : S_IF;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        mem_read  = is_load  && !io;
        io_read   = is_load  &&  io;
        mem_write = is_store && !io;
        io_write  = is_store &&  io;
        if (mem_exit) begin
          state_d = is_load ? S_WB : S_IF;
        end else if (wcnt_q == CW'(TIMEOUT)) begin
          bus_error = 1'b1;
          state_d   = S_EXC;
        end
      end
      S_WB: begin
        reg_write = 1'b1;
        state_d   = S_IF;
      end
      S_EXC: begin
        exc_entry = 1'b1;
        pc_sel    = PC_VEC;
        state_d   = S_IF;
      end
      default: state_d = S_INIT;
    endcase
  end

  // Counter runs only while staying in MEM, so it is zero on every MEM entry.
  assign wcnt_d = (state_q == S_MEM && state_d == S_MEM) ? wcnt_q + CW'(1) : '0;

  always_ff @(posedge clock or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      state_q <= S_INIT;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_mc_sequencer.sv
// Scoreboard bench for mc_sequencer (MEM_WAIT=2, TIMEOUT=15): expected per-cycle
// outputs are queued with the stimulus and compared mid-cycle.
module tb_mc_sequencer;

  localparam int MW = 2;
  localparam int TO = 15;

  localparam logic [2:0] ST_INIT = 3'd0, ST_IF = 3'd1, ST_ID = 3'd2, ST_EXE = 3'd3,
                         ST_MEM = 3'd4, ST_WB = 3'd5, ST_EXC = 3'd6;
  localparam logic [2:0] P0 = 3'b000, P4 = 3'b001, PJ = 3'b010, PB = 3'b011,
                         PV = 3'b100, PE = 3'b101;
  // Flag order: wir, waluresult, reg_write, mem_read, mem_write, io_read, io_write, exc_entry, bus_error
  localparam logic [8:0] F0 = 9'h000, F_WIR = 9'h100, F_ALU = 9'h080, F_RW = 9'h040,
                         F_MR = 9'h020, F_MW = 9'h010, F_IOR = 9'h008, F_IOW = 9'h004,
                         F_EXC = 9'h002, F_BE = 9'h001;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        is_jump, is_link, is_branch, branch_taken, is_load, is_store;
  logic        is_muldiv, muldiv_done, except_req, is_eret, int_req, mem_ready;
  logic [21:0] addr_high;
  logic [2:0]  pc_sel, state;
  logic        wir, waluresult, reg_write, mem_read, mem_write, io_read, io_write;
  logic        exc_entry, bus_error;

  int n_checks = 0;
  int n_fail   = 0;
  logic [14:0] exp_q[$];
  string       name_q[$];

  mc_sequencer #(.ADDR_HI_W(22), .MEM_WAIT(MW), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset),
    .is_jump(is_jump), .is_link(is_link), .is_branch(is_branch),
    .branch_taken(branch_taken), .is_load(is_load), .is_store(is_store),
    .is_muldiv(is_muldiv), .muldiv_done(muldiv_done), .except_req(except_req),
    .is_eret(is_eret), .int_req(int_req), .addr_high(addr_high),
    .mem_ready(mem_ready), .pc_sel(pc_sel), .wir(wir), .waluresult(waluresult),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .io_read(io_read), .io_write(io_write), .exc_entry(exc_entry),
    .bus_error(bus_error), .state(state)
  );

  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  function automatic logic [14:0] observed();
    return {pc_sel, wir, waluresult, reg_write, mem_read, mem_write,
            io_read, io_write, exc_entry, bus_error, state};
  endfunction

  task automatic clear_inputs();
    is_jump = 0; is_link = 0; is_branch = 0; branch_taken = 0; is_load = 0;
    is_store = 0; is_muldiv = 0; muldiv_done = 0; except_req = 0; is_eret = 0;
    int_req = 0; mem_ready = 0; addr_high = '0;
  endtask

  // Queue this cycle's expectation, pop and compare at the falling edge, advance.
  task automatic step(input string nm, input logic [2:0] st, input logic [2:0] pc,
                      input logic [8:0] fl);
    logic [14:0] e, o;
    string       n;
    exp_q.push_back({pc, fl, st});
    name_q.push_back(nm);
    @(negedge clock);
    e = exp_q.pop_front();
    n = name_q.pop_front();
    o = observed();
    n_checks++;
    if (o !== e) begin
      n_fail++;
      $display("FAIL %s: got pc_sel=%b flags=%b state=%0d, required pc_sel=%b flags=%b state=%0d",
               n, o[14:12], o[11:3], o[2:0], e[14:12], e[11:3], e[2:0]);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    #1 reset = 1'b1;
    #1;
    n_checks++;
    if (observed() !== 15'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b, required all zero", observed());
    end
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    step("init", ST_INIT, P0, F0);
  endtask

  task automatic test_alu();
    clear_inputs();
    step("alu_if",  ST_IF,  P4, F_WIR);
    step("alu_id",  ST_ID,  P0, F0);
    step("alu_exe", ST_EXE, P0, F_ALU);
    step("alu_wb",  ST_WB,  P0, F_RW);
  endtask

  task automatic test_load_ram();
    clear_inputs();
    is_load = 1; mem_ready = 1;
    step("lw_if",  ST_IF,  P4, F_WIR);
    step("lw_id",  ST_ID,  P0, F0);
    step("lw_exe", ST_EXE, P0, F_ALU);
    for (int i = 0; i <= MW; i++) step($sformatf("lw_mem%0d", i), ST_MEM, P0, F_MR);
    step("lw_wb",  ST_WB,  P0, F_RW);
  endtask

  task automatic test_load_late_ready();
    clear_inputs();
    is_load = 1;
    step("lwl_if",  ST_IF,  P4, F_WIR);
    step("lwl_id",  ST_ID,  P0, F0);
    step("lwl_exe", ST_EXE, P0, F_ALU);
    for (int i = 0; i <= MW; i++) step($sformatf("lwl_wait%0d", i), ST_MEM, P0, F_MR);
    mem_ready = 1;
    step("lwl_ready", ST_MEM, P0, F_MR);
    mem_ready = 0;
    step("lwl_wb", ST_WB, P0, F_RW);
  endtask

  task automatic test_store_io();
    clear_inputs();
    is_store = 1; addr_high = '1;
    step("swio_if",  ST_IF,  P4, F_WIR);
    step("swio_id",  ST_ID,  P0, F0);
    step("swio_exe", ST_EXE, P0, F_ALU);
    for (int i = 0; i <= MW; i++) step($sformatf("swio_mem%0d", i), ST_MEM, P0, F_IOW);
  endtask

  task automatic test_timeout();
    clear_inputs();
    is_load = 1;
    step("to_if",  ST_IF,  P4, F_WIR);
    step("to_id",  ST_ID,  P0, F0);
    step("to_exe", ST_EXE, P0, F_ALU);
    for (int i = 0; i < TO; i++) step($sformatf("to_mem%0d", i), ST_MEM, P0, F_MR);
    step("to_berr", ST_MEM, P0, F_MR | F_BE);
    step("to_exc",  ST_EXC, PV, F_EXC);
  endtask

  task automatic test_timeout_race();
    clear_inputs();
    is_load = 1;
    step("tr_if",  ST_IF,  P4, F_WIR);
    step("tr_id",  ST_ID,  P0, F0);
    step("tr_exe", ST_EXE, P0, F_ALU);
    for (int i = 0; i < TO; i++) step($sformatf("tr_mem%0d", i), ST_MEM, P0, F_MR);
    mem_ready = 1;
    step("tr_last", ST_MEM, P0, F_MR);
    mem_ready = 0;
    step("tr_wb", ST_WB, P0, F_RW);
  endtask

  task automatic test_branch();
    clear_inputs();
    is_branch = 1; branch_taken = 1;
    step("beq_if",  ST_IF,  P4, F_WIR);
    step("beq_id",  ST_ID,  P0, F0);
    step("beq_exe", ST_EXE, PB, F_ALU);
    branch_taken = 0;
    step("bne_if",  ST_IF,  P4, F_WIR);
    step("bne_id",  ST_ID,  P0, F0);
    step("bne_exe", ST_EXE, P0, F_ALU);
    branch_taken = 1; is_link = 1;
    step("bgezal_if",  ST_IF,  P4, F_WIR);
    step("bgezal_id",  ST_ID,  P0, F0);
    step("bgezal_exe", ST_EXE, PB, F_ALU);
    step("bgezal_wb",  ST_WB,  P0, F_RW);
  endtask

  task automatic test_jump();
    clear_inputs();
    is_jump = 1; is_link = 1;
    step("jal_if", ST_IF, P4, F_WIR);
    step("jal_id", ST_ID, PJ, F_RW);
    is_link = 0;
    step("j_if", ST_IF, P4, F_WIR);
    step("j_id", ST_ID, PJ, F0);
  endtask

  task automatic test_muldiv();
    clear_inputs();
    is_muldiv = 1;
    step("div_if", ST_IF, P4, F_WIR);
    step("div_id", ST_ID, P0, F0);
    for (int i = 0; i < 5; i++) step($sformatf("div_stall%0d", i), ST_EXE, P0, F_ALU);
    muldiv_done = 1;
    step("div_done", ST_EXE, P0, F_ALU);
    muldiv_done = 0;
    step("div_wb", ST_WB, P0, F_RW);
  endtask

  task automatic test_interrupt();
    clear_inputs();
    int_req = 1;
    step("int_if",  ST_IF,  P0, F0);
    step("int_exc", ST_EXC, PV, F_EXC);
    int_req = 0;
    step("defer_if", ST_IF, P4, F_WIR);
    int_req = 1;
    step("defer_id",  ST_ID,  P0, F0);
    step("defer_exe", ST_EXE, P0, F_ALU);
    step("defer_wb",  ST_WB,  P0, F_RW);
    step("defer_int", ST_IF,  P0, F0);
    step("defer_exc", ST_EXC, PV, F_EXC);
  endtask

  task automatic test_except();
    clear_inputs();
    except_req = 1; is_jump = 1;
    step("sys_if",  ST_IF,  P4, F_WIR);
    step("sys_id",  ST_ID,  P0, F0);
    step("sys_exc", ST_EXC, PV, F_EXC);
    except_req = 0; is_eret = 1;
    step("eret_if", ST_IF, P4, F_WIR);
    step("eret_id", ST_ID, PE, F0);
  endtask

  task automatic test_reset_mem();
    clear_inputs();
    is_store = 1;
    step("rsw_if",   ST_IF,  P4, F_WIR);
    step("rsw_id",   ST_ID,  P0, F0);
    step("rsw_exe",  ST_EXE, P0, F_ALU);
    step("rsw_mem0", ST_MEM, P0, F_MW);
    reset = 1'b1;
    #1;
    n_checks++;
    if (mem_write !== 1'b0 || state !== ST_INIT) begin
      n_fail++;
      $display("FAIL rst_mem_async: got mem_write=%b state=%0d, required 0 and 0", mem_write, state);
    end
    step("rst_mem_hold", ST_INIT, P0, F0);
    reset = 1'b0;
    clear_inputs();
    step("rst_mem_init", ST_INIT, P0, F0);
    step("rst_mem_if",   ST_IF,   P4, F_WIR);
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_ram();
    test_load_late_ready();
    test_store_io();
    test_timeout();
    test_timeout_race();
    test_branch();
    test_jump();
    test_muldiv();
    test_interrupt();
    test_except();
    test_reset_mem();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_sequencer.md
# mc_sequencer

Parametrised multicycle sequencer for the Minisys-1A CPU. It steps each instruction through fetch, decode, execute, memory and write-back, producing the PC, IR, ALU-result and register-file write strobes. Over the fixed-latency controller it adds memory wait states with a ready handshake and a bus timeout, multi-cycle mul/div stalls, and an exception/interrupt entry state. Instruction decode stays outside this block; it consumes decoded class flags.

## Interface
- `ADDR_HI_W`, 22: width of `addr_high`. All-ones selects IO space.
- `MEM_WAIT`, 0: minimum extra cycles spent in MEM before it may exit.
- `TIMEOUT`, 15: MEM cycle index at which a missing `mem_ready` becomes a bus error. Must satisfy TIMEOUT > MEM_WAIT.
- `clock` in 1: rising-edge clock.
- `reset` in 1: reset, asynchronous, active-high.
- `is_jump` in 1: j/jal/jr/jalr.
- `is_link` in 1: jal/jalr/bgezal/bltzal.
- `is_branch` in 1: any conditional branch.
- `branch_taken` in 1: branch condition true, valid in EXE.
- `is_load`, `is_store` in 1: load or store class.
- `is_muldiv` in 1: mult/multu/div/divu.
- `muldiv_done` in 1: mul/div unit result ready.
- `except_req` in 1: reserved instruction, syscall or break.
- `is_eret` in 1: eret.
- `int_req` in 1: external interrupt pending and enabled.
- `addr_high` in ADDR_HI_W: ALU result upper bits, valid in MEM.
- `mem_ready` in 1: memory has completed the access.
- `pc_sel` out 3: 000 hold, 001 PC+4, 010 jump target, 011 branch target, 100 exception vector, 101 EPC.
- `wir` out 1: load IR.
- `waluresult` out 1: load ALU result register.
- `reg_write` out 1: register-file write strobe.
- `mem_read`, `mem_write`, `io_read`, `io_write` out 1: bus strobes.
- `exc_entry` out 1: save EPC/cause.
- `bus_error` out 1: cause qualifier for a timeout.
- `state` out 3: current state, for debug.

## Operation
- States: INIT=0, IF=1, ID=2, EXE=3, MEM=4, WB=5, EXC=6. Codes 7 and any illegal code go to INIT.
- Outputs are combinational from the registered state and the current inputs. Every output not listed for a state is 0.
- INIT: next state IF.
- IF:
  - If `int_req`=1: go to EXC; `wir`=0 and `pc_sel`=000.
  - Otherwise: `wir`=1, `pc_sel`=001, go to ID.
- ID, in priority order:
  - `except_req`: go to EXC.
  - `is_eret`: `pc_sel`=101, go to IF.
  - `is_jump`: `pc_sel`=010, `reg_write`=`is_link`, go to IF.
  - Otherwise: go to EXE.
- EXE: `waluresult`=1.
  - `is_muldiv` and !`muldiv_done`: stay in EXE.
  - `is_load` or `is_store`: go to MEM.
  - `is_branch`: `pc_sel`=011 if `branch_taken`, else 000. Go to WB if `is_link`, else IF.
  - Otherwise: go to WB.
- MEM:
  - `io` = (`addr_high` == all-ones).
  - Strobes: `mem_read`=`is_load`&!`io`, `io_read`=`is_load`&`io`, `mem_write`=`is_store`&!`io`, `io_write`=`is_store`&`io`. All are held for every MEM cycle.
  - `wcnt` is cleared on MEM entry and increments each MEM cycle.
  - Exit condition: `wcnt` >= MEM_WAIT and (`io` or `mem_ready`). On exit, a load goes to WB and a store goes to IF.
  - If the exit condition is false and `wcnt`==TIMEOUT: `bus_error`=1, go to EXC.
  - IO accesses ignore `mem_ready`.
- WB: `reg_write`=1 for exactly one cycle, then go to IF.
- EXC: `exc_entry`=1 and `pc_sel`=100 for one cycle, then go to IF.
- `wcnt` width is $clog2(TIMEOUT+1). It never wraps, because the timeout forces exit first.

## Timing
- Reset clears `state` to INIT and `wcnt` to 0 immediately. Every output reads 0 while `reset`=1.
- Reset during MEM drops the bus strobes asynchronously. No write completes.
- State and `wcnt` update on the rising edge of `clock`.
- Latencies:
  - ALU instruction: IF-ID-EXE-WB, 4 cycles.
  - Jump: 2 cycles.
  - Untaken branch, no link: 3 cycles.
  - Load: 5+MEM_WAIT cycles minimum.
  - Store: 4+MEM_WAIT cycles minimum.
  - Mul/div: EXE is extended until `muldiv_done` is seen.
- `mem_ready` is sampled combinationally in MEM. If it asserts with `wcnt` < MEM_WAIT, the access still waits until `wcnt` reaches MEM_WAIT.
- Simultaneous events:
  - `mem_ready` on the timeout cycle: a normal exit wins; no bus error.
  - `int_req` arriving outside IF is deferred to the next IF, i.e. the next instruction boundary.

## Test plan
- add, MEM_WAIT=0: states 1,2,3,5,1. `reg_write`=1 only in cycle 4. `pc_sel`=001 only in cycle 1.
- lw at a RAM address, MEM_WAIT=2, `mem_ready`=1: `mem_read` held for exactly 3 cycles, then WB, then IF. Total 7 cycles.
- sw at `addr_high`=all-ones, MEM_WAIT=1, `mem_ready`=0: `io_write` held 2 cycles, `mem_write`=0, then IF, no bus error.
- lw, TIMEOUT=15, `mem_ready`=0: 16 MEM cycles; `bus_error`=1 on the 16th; then EXC with `exc_entry`=1 and `pc_sel`=100; then IF.
- Cases covering `pc_sel`, link and stall behaviour:
  - Taken beq: `pc_sel`=011 in EXE, next state IF.
  - bgezal: then WB with `reg_write`=1.
  - jal: `reg_write`=1 and `pc_sel`=010 in ID.
  - div with `muldiv_done` high after 5 cycles: EXE lasts 6 cycles.
- Exception and reset cases:
  - `int_req`=1 in IF: `wir`=0, then EXC.
  - `except_req` in ID: EXC.
  - `reset` pulsed mid-MEM: all strobes 0 the same cycle, `state`=0.
